// File: rtl/itch_byte_decoder.sv
// itch_byte_decoder: byte-serial ITCH 5.0 parser feeding the order-book engine.
// Consumes length-prefixed messages one byte per cycle, extracts the fields of
// book-affecting messages and emits one registered instruction per message
// under a valid/ready handshake. Unsupported types are skipped; broken framing
// is counted and the parser resynchronises on the next length prefix.

package itch_byte_decoder_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ADD     = 3'd1,
    OP_EXEC    = 3'd2,
    OP_CANCEL  = 3'd3,
    OP_DELETE  = 3'd4,
    OP_REPLACE = 3'd5
  } opcode_t;

  typedef enum logic {
    SIDE_BID = 1'b0,
    SIDE_ASK = 1'b1
  } side_t;

  typedef struct packed {
    opcode_t     opcode;
    logic        valid;
    logic [63:0] timestamp;
    side_t       side;
    logic [47:0] order_id;
    logic [47:0] price;
    logic [31:0] quantity;
    logic [47:0] new_order_id;
    logic        last_in_bundle;
  } instr_t;

  // ITCH message type bytes this decoder understands.
  localparam logic [7:0] T_ADD      = 8'h41; // 'A'
  localparam logic [7:0] T_ADD_MPID = 8'h46; // 'F'
  localparam logic [7:0] T_EXEC     = 8'h45; // 'E'
  localparam logic [7:0] T_CANCEL   = 8'h58; // 'X'
  localparam logic [7:0] T_DELETE   = 8'h44; // 'D'
  localparam logic [7:0] T_REPLACE  = 8'h55; // 'U'

  localparam logic [7:0] SIDE_CHAR_BID = 8'h42; // 'B'
  localparam logic [7:0] SIDE_CHAR_ASK = 8'h53; // 'S'

endpackage

module itch_byte_decoder
  import itch_byte_decoder_pkg::*;
#(
  parameter int MIN_LEN_CHECK = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic [7:0]       in_tdata,
  input  logic             in_tlast,
  output logic             out_v,
  input  logic             out_r,
  output logic [2:0]       out_opcode,
  output logic             out_valid,
  output logic [63:0]      out_timestamp,
  output logic             out_side,
  output logic [47:0]      out_order_id,
  output logic [47:0]      out_price,
  output logic [31:0]      out_quantity,
  output logic [47:0]      out_new_order_id,
  output logic             out_last_in_bundle,
  output logic [31:0]      msg_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    BODY   = 3'd2,
    SKIP   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // Opcode for a type byte; OP_NOP marks an unsupported type.
  function automatic opcode_t type_to_op(input logic [7:0] t);
    case (t)
      T_ADD, T_ADD_MPID: return OP_ADD;
      T_EXEC:            return OP_EXEC;
      T_CANCEL:          return OP_CANCEL;
      T_DELETE:          return OP_DELETE;
      T_REPLACE:         return OP_REPLACE;
      default:           return OP_NOP;
    endcase
  endfunction

  // Smallest declared length that still covers every field we parse.
  function automatic logic [15:0] type_min_len(input logic [7:0] t);
    case (t)
      T_ADD, T_ADD_MPID: return 16'd36;
      T_EXEC:            return 16'd31;
      T_CANCEL:          return 16'd23;
      T_DELETE:          return 16'd19;
      T_REPLACE:         return 16'd35;
      default:           return 16'd0;
    endcase
  endfunction

  function automatic logic in_rng(input logic [15:0] i, input int lo, input int hi);
    return (int'(i) >= lo) && (int'(i) <= hi);
  endfunction

  // Shift one body byte into whichever field owns its offset. Capture fields
  // start from zero, so shifting big-endian bytes in leaves the value
  // zero-extended, and wide references keep only their low 48 bits.
  function automatic instr_t capture(input instr_t c, input logic [7:0] t,
                                     input logic [15:0] i, input logic [7:0] b);
    instr_t r;
    r = c;
    if (in_rng(i, 5, 10))  r.timestamp = {16'h0, c.timestamp[39:0], b};
    if (in_rng(i, 11, 18)) r.order_id  = {c.order_id[39:0], b};
    case (t)
      T_ADD, T_ADD_MPID: begin
        if (i == 16'd19)       r.side     = (b == SIDE_CHAR_ASK) ? SIDE_ASK : SIDE_BID;
        if (in_rng(i, 20, 23)) r.quantity = {c.quantity[23:0], b};
        if (in_rng(i, 32, 35)) r.price    = {c.price[39:0], b};
      end
      T_EXEC, T_CANCEL: begin
        if (in_rng(i, 19, 22)) r.quantity = {c.quantity[23:0], b};
      end
      T_REPLACE: begin
        if (in_rng(i, 19, 26)) r.new_order_id = {c.new_order_id[39:0], b};
        if (in_rng(i, 27, 30)) r.quantity     = {c.quantity[23:0], b};
        if (in_rng(i, 31, 34)) r.price        = {c.price[39:0], b};
      end
      default: ;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  type_q, type_d;
  logic        bad_side_q, bad_side_d;
  instr_t      cap_q, cap_d;
  instr_t      out_q, out_d;
  logic        out_v_q, out_v_d;

  logic [31:0]      msg_q;
  logic [CNT_W-1:0] drop_q, err_q;
  logic             drop_inc, err_inc;

  logic        byte_ok;
  logic        can_write;
  logic        is_final;
  logic [7:0]  cur_type;
  opcode_t     cur_op;
  logic        cur_af;
  logic        emit;
  instr_t      emit_word;
  instr_t      nop_last;

  assign byte_ok   = in_tvalid && (state_q != HOLD);
  assign can_write = !out_v_q || out_r;
  assign is_final  = (idx_q == (len_q - 16'd1));
  // Body byte 0 is the type; after that the latched copy is authoritative.
  assign cur_type  = (idx_q == 16'd0) ? in_tdata : type_q;
  assign cur_op    = type_to_op(cur_type);
  assign cur_af    = (cur_type == T_ADD) || (cur_type == T_ADD_MPID);

  // Bundle-close marker for a packet whose final message produced nothing.
  always_comb begin
    nop_last                = '0;
    nop_last.last_in_bundle = 1'b1;
  end

  // Next-state, field capture, counter events and output-register write.
  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    type_d     = type_q;
    bad_side_d = bad_side_q;
    cap_d      = cap_q;
    out_d      = out_q;
    out_v_d    = out_v_q;
    drop_inc   = 1'b0;
    err_inc    = 1'b0;
    emit       = 1'b0;
    emit_word  = '0;

    if (out_v_q && out_r) out_v_d = 1'b0;

    case (state_q)
      LEN_HI: begin
        if (byte_ok) begin
          len_d = {in_tdata, len_q[7:0]};
          if (in_tlast) begin
            err_inc   = 1'b1;
            emit      = 1'b1;
            emit_word = nop_last;
          end else begin
            state_d = LEN_LO;
          end
        end
      end

      LEN_LO: begin
        if (byte_ok) begin
          len_d = {len_q[15:8], in_tdata};
          if (in_tlast) begin
            err_inc   = 1'b1;
            emit      = 1'b1;
            emit_word = nop_last;
          end else if ({len_q[15:8], in_tdata} == 16'd0) begin
            err_inc = 1'b1;
            state_d = LEN_HI;
          end else begin
            state_d    = BODY;
            idx_d      = '0;
            type_d     = '0;
            bad_side_d = 1'b0;
            cap_d      = '0;
          end
        end
      end

      BODY: begin
        if (byte_ok) begin
          idx_d = idx_q + 16'd1;
          if (idx_q == 16'd0) type_d = in_tdata;
          cap_d = capture(cap_q, cur_type, idx_q, in_tdata);
          if (cur_af && (idx_q == 16'd19) &&
              (in_tdata != SIDE_CHAR_BID) && (in_tdata != SIDE_CHAR_ASK))
            bad_side_d = 1'b1;

          if (in_tlast && !is_final) begin
            // Packet ended inside the message: drop the partial instruction.
            err_inc   = 1'b1;
            emit      = 1'b1;
            emit_word = nop_last;
          end else if (cur_op == OP_NOP) begin
            drop_inc = 1'b1;
            if (is_final) begin
              if (in_tlast) begin
                emit      = 1'b1;
                emit_word = nop_last;
              end else begin
                state_d = LEN_HI;
              end
            end else begin
              state_d = SKIP;
            end
          end else if (is_final) begin
            if (bad_side_d ||
                ((MIN_LEN_CHECK != 0) && (len_q < type_min_len(cur_type)))) begin
              err_inc = 1'b1;
              if (in_tlast) begin
                emit      = 1'b1;
                emit_word = nop_last;
              end else begin
                state_d = LEN_HI;
              end
            end else begin
              emit                     = 1'b1;
              emit_word                = cap_d;
              emit_word.opcode         = cur_op;
              emit_word.valid          = 1'b1;
              emit_word.last_in_bundle = in_tlast;
            end
          end
        end
      end

      SKIP: begin
        if (byte_ok) begin
          idx_d = idx_q + 16'd1;
          if (in_tlast) begin
            if (!is_final) err_inc = 1'b1;
            emit      = 1'b1;
            emit_word = nop_last;
          end else if (is_final) begin
            state_d = LEN_HI;
          end
        end
      end

      HOLD: begin
        // The pending instruction waits in the capture register.
        if (can_write) begin
          out_d   = cap_q;
          out_v_d = 1'b1;
          state_d = LEN_HI;
        end
      end

      default: state_d = LEN_HI;
    endcase

    if (emit) begin
      cap_d = emit_word;
      if (can_write) begin
        out_d   = emit_word;
        out_v_d = 1'b1;
        state_d = LEN_HI;
      end else begin
        state_d = HOLD;
      end
    end
  end

  // Parser state, capture and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LEN_HI;
      len_q      <= '0;
      idx_q      <= '0;
      type_q     <= '0;
      bad_side_q <= 1'b0;
      cap_q      <= '0;
      out_q      <= '0;
      out_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      bad_side_q <= bad_side_d;
      cap_q      <= cap_d;
      out_q      <= out_d;
      out_v_q    <= out_v_d;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msg_q  <= '0;
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      if (out_v_q && out_r && out_q.valid && (msg_q != '1)) msg_q <= msg_q + 32'd1;
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      if (err_inc && (err_q != '1))   err_q  <= err_q + CNT_W'(1);
    end
  end

  assign in_tready          = (state_q != HOLD);
  assign out_v              = out_v_q;
  assign out_opcode         = out_q.opcode;
  assign out_valid          = out_q.valid;
  assign out_timestamp      = out_q.timestamp;
  assign out_side           = out_q.side;
  assign out_order_id       = out_q.order_id;
  assign out_price          = out_q.price;
  assign out_quantity       = out_q.quantity;
  assign out_new_order_id   = out_q.new_order_id;
  assign out_last_in_bundle = out_q.last_in_bundle;
  assign msg_count          = msg_q;
  assign drop_count         = drop_q;
  assign err_count          = err_q;

endmodule

// File: doc/itch_byte_decoder.md
Name: itch_byte_decoder

Overview:
Byte-serial ITCH 5.0 decoder that sits directly upstream of pipebomb_top and drives its s_* instruction interface. It consumes a length-prefixed ITCH message stream (MoldUDP64 header already stripped) one byte per cycle and parses the fields. Book-affecting messages are emitted as one registered instruction each, under a valid/ready handshake. All other message types are skipped, and malformed framing is detected and resynchronised.

Parameters:
MIN_LEN_CHECK, 1, when 1 a declared length below the type's minimum is dropped and counted as an error; when 0 such a message is still emitted.
CNT_W, 16, width of the drop and error counters.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_tvalid  in  1  stream byte valid
in_tready  out  1  stream byte ready
in_tdata  in  8  stream byte
in_tlast  in  1  last byte of a MoldUDP64 packet (bundle)
out_v  out  1  instruction valid (to s_v)
out_r  in  1  instruction ready (from s_r)
out_opcode  out  3  pipebomb_pkg opcode_t
out_valid  out  1  instruction carries a real message
out_timestamp  out  64  ITCH ns timestamp, zero-extended
out_side  out  1  pipebomb_pkg side_t
out_order_id  out  48  order reference, low 48 bits
out_price  out  48  price, zero-extended from 32 bits
out_quantity  out  32  shares
out_new_order_id  out  48  replace new reference, low 48 bits
out_last_in_bundle  out  1  instruction closes the bundle
msg_count  out  32  instructions with out_valid=1 accepted downstream (saturating)
drop_count  out  CNT_W  skipped unsupported types (saturating)
err_count  out  CNT_W  framing/length errors (saturating)

Behaviour:
- Reset: FSM=LEN_HI; out_v=0; all out_* fields=0; counters=0; in_tready=1.
- FSM states: LEN_HI, LEN_LO, BODY, SKIP, HOLD.
  - LEN_HI/LEN_LO capture the 16-bit big-endian length L.
  - Entering BODY clears the byte index and capture registers.
  - Body byte 0 is the type.
  - A non-supported type goes to SKIP for the remaining L-1 bytes and increments drop_count once.
- Supported types and body offsets (big-endian; index 0 is the type byte):
  - A (L≥36) and F (L≥36): ts[5:10], ref[11:18], side[19] ('B'→SIDE_BID, 'S'→SIDE_ASK, other→error), shares[20:23], price[32:35]. Opcode ADD.
  - E (L≥31): ts, ref, shares[19:22]. Opcode EXEC.
  - X (L≥23): ts, ref, shares[19:22]. Opcode CANCEL.
  - D (L≥19): ts, ref. Opcode DELETE.
  - U (L≥35): ts, orig ref[11:18]→order_id, new ref[19:26], shares[27:30], price[31:34]. Opcode REPLACE.
  - Unused fields are 0. side is 0 except for A/F; the order map resolves side downstream.
  - Bytes beyond the parsed offsets (e.g. the F MPID) are consumed and ignored.
- Length errors:
  - L=0: err_count++ and return to LEN_HI.
  - L below the type minimum with MIN_LEN_CHECK=1: consume the body, err_count++, no emit.
- tlast before the declared length is exhausted, or tlast on a length byte: err_count++, discard the partial message, go to LEN_HI. No in-progress message is emitted.
- Emit:
  - On acceptance of the final body byte, if (!out_v || out_r), the instruction is written to the output register, out_v=1 the next cycle, and the FSM goes to LEN_HI. Latency is 1 cycle from the last byte.
  - Otherwise the FSM goes to HOLD with in_tready=0 and writes once (!out_v || out_r).
  - out_valid=1 and out_last_in_bundle=in_tlast of the final byte.
- Bundle close with no payload:
  - If tlast ends a skipped, dropped or errored message, emit NOP with out_valid=0 and out_last_in_bundle=1.
  - This uses the same emit/HOLD rules and the same latency as a normal emit.
- in_tready=0 only in HOLD. Otherwise one byte per cycle.
- Output register: fields are stable while out_v && !out_r; out_v clears on handshake if no new write occurs that cycle.
- Counters saturate at all-ones.
- msg_count increments on each out_v&&out_r with out_valid=1.
- Reset mid-message discards all state and returns to the reset values.

Test Plan:
- Add, L=36, type 'A', ts=0x0000_1234_5678, ref=0x0000_0000_00AB_CDEF, side='S', shares=100, price=0x0001_86A0, tlast on last byte, out_r=1:
  - exactly 1 cycle after the last byte: out_v=1, out_opcode=ADD, out_side=SIDE_ASK, out_price=0x186A0, out_quantity=100, out_order_id=0xABCDEF, out_last_in_bundle=1;
  - msg_count=1.
- Replace 'U' (orig=5, new=9, shares=50, price=200) followed by 'D' ref=9 in one packet, tlast on the D:
  - two instructions in order, REPLACE then DELETE;
  - out_new_order_id=9;
  - out_last_in_bundle=0 on the first and 1 on the second.
- Hold out_r=0 for 10 cycles with three back-to-back 'X' messages:
  - in_tready drops in HOLD after the second message completes;
  - no byte or instruction is lost;
  - all three emerge in order once out_r=1.
- Type 'S' (L=12) that is last in its packet:
  - drop_count=1;
  - a single NOP with out_valid=0 and out_last_in_bundle=1 is emitted.
- 'A' with L=36 but tlast at body byte 20:
  - err_count=1, no ADD emitted, NOP with last_in_bundle emitted;
  - a following valid 'D' decodes correctly.
- Assert rstn low mid-body, then send a valid 'E':
  - all outputs and counters are 0 during reset;
  - the 'E' decodes correctly afterwards.
